ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  Pipeline register between the execute stage (ALU) and data memory. Captures the ALU
//  result, branch condition and EX-stage control bits, resolves branches/jumps under a
//  predict-not-taken policy, and issues a registered one-cycle PC redirect upstream.
//  Squashes the wrong-path instruction that is in EX while its own redirect is asserted.
// PARAMETERS
//  XLEN  32  datapath width (PC, ALU result, store data)
//  RIDX  5   register index width
// PORTS
//  clk              in   1     clock; all state updates on rising edge
//  reset            in   1     synchronous, active-high reset
//  stall            in   1     hold all state this cycle (hazard unit)
//  flush            in   1     load a bubble this cycle (external kill)
//  ex_valid         in   1     EX holds a real instruction
//  ex_pc            in   XLEN  PC of EX instruction
//  ex_imm           in   XLEN  sign-extended immediate
//  alu_result       in   XLEN  ALU output (rs1+imm for JALR)
//  alu_bcond        in   1     ALU branch-condition output
//  ex_rs2_data      in   XLEN  store data
//  ex_rd            in   RIDX  destination register
//  ex_is_branch/ex_is_jal/ex_is_jalr  in 1 each  control-flow class (one-hot or none)
//  ex_mem_read/ex_mem_write/ex_reg_write/ex_mem_to_reg/ex_halt  in 1 each  control
//  mem_valid        out  1     MEM holds a real instruction
//  mem_alu_result   out  XLEN  ALU result, or ex_pc+4 for JAL/JALR (link value)
//  mem_rs2_data     out  XLEN  registered store data
//  mem_rd           out  RIDX  registered destination
//  mem_mem_read/mem_mem_write/mem_reg_write/mem_mem_to_reg/mem_halt  out 1 each
//  redirect         out  1     registered: fetch must load redirect_target
//  redirect_target  out  XLEN  new PC
// BEHAVIOUR
//  - Clock clk, reset synchronous active-high. Reset: every output 0, halted flag 0.
//  - Priority per edge: reset > flush > stall > capture.
//  - flush: load bubble (mem_valid and all mem_* control 0, data regs 0), redirect 0.
//  - stall: every register incl. redirect/redirect_target and halted keeps its value.
//  - capture: live = ex_valid & ~redirect & ~halted. If live=0 load a bubble, redirect 0.
//    If live=1: copy data/control; mem_valid=1.
//  - taken = ex_is_jal | ex_is_jalr | (ex_is_branch & alu_bcond), evaluated only when live.
//  - Target: branch/JAL -> ex_pc+ex_imm; JALR -> alu_result & ~1. All adds mod 2^XLEN.
//  - redirect<=taken&live, redirect_target<=target (0 when not taken). Latency 1 cycle;
//    redirect is a one-cycle pulse because the next capture sees redirect=1 and squashes.
//  - Branch (not JAL/JALR): mem_reg_write forced 0, mem_alu_result = alu_result.
//  - JAL/JALR: mem_alu_result = ex_pc+4; other control copied as given.
//  - halted set when a live ex_halt is captured; sticky until reset (flush does not clear).
//    mem_halt asserted with that instruction; subsequent captures are bubbles.
//  - Squashed or non-live instructions never raise redirect, halted or any mem_* control.
//  - No combinational path from any input to any output.
// TESTING
//  1 reset=1 with all inputs 1 -> next edge all outputs 0; stays 0 while reset held.
//  2 ADD: ex_valid=1, alu_result=0x0000_0010, rd=5, reg_write=1 -> next cycle mem_valid=1,
//    mem_alu_result=0x10, mem_rd=5, redirect=0.
//  3 BEQ taken: pc=0x100, imm=0x20, bcond=1 -> redirect=1, target=0x120, mem_reg_write=0;
//    following EX instr (valid=1, reg_write=1) captured as bubble; redirect back to 0.
//  4 JALR: pc=0x200, alu_result=0x0000_0305 -> target=0x304, mem_alu_result=0x204,
//    redirect=1; JAL pc=0xFFFF_FFFC imm=8 -> target=0x4 (wrap).
//  5 Taken branch with stall=1 for 2 cycles -> redirect/target held 2 cycles; flush=1 with
//    stall=1 -> bubble, redirect=0.
//  6 Live ex_halt -> mem_halt=1 one cycle, then bubbles for any ex_valid=1 until reset.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bundle: hazard controls, EX-side inputs, MEM-side outputs.
// The stage drives the slave side; the producer/consumer side is the master.
interface ex_mem_stage_if #(
    parameter int XLEN = 32,
    parameter int RIDX = 5
);
    logic            stall;
    logic            flush;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] alu_result;
    logic            alu_bcond;
    logic [XLEN-1:0] ex_rs2_data;
    logic [RIDX-1:0] ex_rd;
    logic            ex_is_branch;
    logic            ex_is_jal;
    logic            ex_is_jalr;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_reg_write;
    logic            ex_mem_to_reg;
    logic            ex_halt;

    logic            mem_valid;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_rs2_data;
    logic [RIDX-1:0] mem_rd;
    logic            mem_mem_read;
    logic            mem_mem_write;
    logic            mem_reg_write;
    logic            mem_mem_to_reg;
    logic            mem_halt;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;

    modport slave (
        input  stall, flush, ex_valid, ex_pc, ex_imm, alu_result,
        input  alu_bcond, ex_rs2_data, ex_rd,
        input  ex_is_branch, ex_is_jal, ex_is_jalr,
        input  ex_mem_read, ex_mem_write, ex_reg_write,
        input  ex_mem_to_reg, ex_halt,
        output mem_valid, mem_alu_result, mem_rs2_data, mem_rd,
        output mem_mem_read, mem_mem_write, mem_reg_write,
        output mem_mem_to_reg, mem_halt,
        output redirect, redirect_target
    );

    modport master (
        output stall, flush, ex_valid, ex_pc, ex_imm, alu_result,
        output alu_bcond, ex_rs2_data, ex_rd,
        output ex_is_branch, ex_is_jal, ex_is_jalr,
        output ex_mem_read, ex_mem_write, ex_reg_write,
        output ex_mem_to_reg, ex_halt,
        input  mem_valid, mem_alu_result, mem_rs2_data, mem_rd,
        input  mem_mem_read, mem_mem_write, mem_reg_write,
        input  mem_mem_to_reg, mem_halt,
        input  redirect, redirect_target
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with predict-not-taken branch resolution
// and a registered one-cycle PC redirect to fetch.
module ex_mem_stage #(
    parameter int XLEN = 32,
    parameter int RIDX = 5
) (
    input  logic           clk,
    input  logic           reset,
    ex_mem_stage_if.slave  bus
);
    logic            mem_valid_q, mem_valid_d;
    logic [XLEN-1:0] mem_alu_result_q, mem_alu_result_d;
    logic [XLEN-1:0] mem_rs2_data_q, mem_rs2_data_d;
    logic [RIDX-1:0] mem_rd_q, mem_rd_d;
    logic            mem_mem_read_q, mem_mem_read_d;
    logic            mem_mem_write_q, mem_mem_write_d;
    logic            mem_reg_write_q, mem_reg_write_d;
    logic            mem_mem_to_reg_q, mem_mem_to_reg_d;
    logic            mem_halt_q, mem_halt_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_target_q, redirect_target_d;
    logic            halted_q, halted_d;

    logic            live;
    logic            taken;
    logic            is_jump;
    logic            load_bubble;
    logic            load_live;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;

    always_comb begin
        // the instruction behind our own redirect is wrong-path
        live        = bus.ex_valid & ~redirect_q & ~halted_q;
        is_jump     = bus.ex_is_jal | bus.ex_is_jalr;
        taken       = is_jump | (bus.ex_is_branch & bus.alu_bcond);
        target      = bus.ex_is_jalr ? (bus.alu_result & ~XLEN'(1))
                                     : (bus.ex_pc + bus.ex_imm);
        link        = bus.ex_pc + XLEN'(4);
        load_bubble = bus.flush | (~bus.stall & ~live);
        load_live   = ~bus.flush & ~bus.stall & live;

        mem_valid_d       = mem_valid_q;
        mem_alu_result_d  = mem_alu_result_q;
        mem_rs2_data_d    = mem_rs2_data_q;
        mem_rd_d          = mem_rd_q;
        mem_mem_read_d    = mem_mem_read_q;
        mem_mem_write_d   = mem_mem_write_q;
        mem_reg_write_d   = mem_reg_write_q;
        mem_mem_to_reg_d  = mem_mem_to_reg_q;
        mem_halt_d        = mem_halt_q;
        redirect_d        = redirect_q;
        redirect_target_d = redirect_target_q;
        halted_d          = halted_q | (load_live & bus.ex_halt);

        if (load_bubble) begin
            mem_valid_d       = 1'b0;
            mem_alu_result_d  = '0;
            mem_rs2_data_d    = '0;
            mem_rd_d          = '0;
            mem_mem_read_d    = 1'b0;
            mem_mem_write_d   = 1'b0;
            mem_reg_write_d   = 1'b0;
            mem_mem_to_reg_d  = 1'b0;
            mem_halt_d        = 1'b0;
            redirect_d        = 1'b0;
            redirect_target_d = '0;
        end else if (load_live) begin
            mem_valid_d       = 1'b1;
            mem_alu_result_d  = is_jump ? link : bus.alu_result;
            mem_rs2_data_d    = bus.ex_rs2_data;
            mem_rd_d          = bus.ex_rd;
            mem_mem_read_d    = bus.ex_mem_read;
            mem_mem_write_d   = bus.ex_mem_write;
            mem_reg_write_d   = bus.ex_reg_write
                              & ~(bus.ex_is_branch & ~is_jump);
            mem_mem_to_reg_d  = bus.ex_mem_to_reg;
            mem_halt_d        = bus.ex_halt;
            redirect_d        = taken;
            redirect_target_d = taken ? target : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q       <= 1'b0;
            mem_alu_result_q  <= '0;
            mem_rs2_data_q    <= '0;
            mem_rd_q          <= '0;
            mem_mem_read_q    <= 1'b0;
            mem_mem_write_q   <= 1'b0;
            mem_reg_write_q   <= 1'b0;
            mem_mem_to_reg_q  <= 1'b0;
            mem_halt_q        <= 1'b0;
            redirect_q        <= 1'b0;
            redirect_target_q <= '0;
            halted_q          <= 1'b0;
        end else begin
            mem_valid_q       <= mem_valid_d;
            mem_alu_result_q  <= mem_alu_result_d;
            mem_rs2_data_q    <= mem_rs2_data_d;
            mem_rd_q          <= mem_rd_d;
            mem_mem_read_q    <= mem_mem_read_d;
            mem_mem_write_q   <= mem_mem_write_d;
            mem_reg_write_q   <= mem_reg_write_d;
            mem_mem_to_reg_q  <= mem_mem_to_reg_d;
            mem_halt_q        <= mem_halt_d;
            redirect_q        <= redirect_d;
            redirect_target_q <= redirect_target_d;
            halted_q          <= halted_d;
        end
    end

    assign bus.mem_valid       = mem_valid_q;
    assign bus.mem_alu_result  = mem_alu_result_q;
    assign bus.mem_rs2_data    = mem_rs2_data_q;
    assign bus.mem_rd          = mem_rd_q;
    assign bus.mem_mem_read    = mem_mem_read_q;
    assign bus.mem_mem_write   = mem_mem_write_q;
    assign bus.mem_reg_write   = mem_reg_write_q;
    assign bus.mem_mem_to_reg  = mem_mem_to_reg_q;
    assign bus.mem_halt        = mem_halt_q;
    assign bus.redirect        = redirect_q;
    assign bus.redirect_target = redirect_target_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random traffic
// checked every cycle against a behavioural model of the stage.
module tb_ex_mem_stage;
    logic clk = 1'b0;
    logic reset;

    ex_mem_stage_if bus ();

    ex_mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // expected architectural state
    logic        m_valid, m_mr, m_mw, m_rw, m_m2r, m_halt;
    logic        m_redir, m_halted;
    logic [31:0] m_alu, m_rs2, m_tgt;
    logic [4:0]  m_rd;

    task automatic expect_eq(input string tag,
                             input logic [31:0] obs,
                             input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_bubble();
        m_valid = 0; m_alu = 0; m_rs2 = 0; m_rd = 0;
        m_mr = 0; m_mw = 0; m_rw = 0; m_m2r = 0; m_halt = 0;
        m_redir = 0; m_tgt = 0;
    endtask

    // what the stage should hold after an edge with the current inputs
    task automatic model_edge();
        bit live, jump, tk;
        if (reset) begin
            model_bubble();
            m_halted = 0;
        end else if (bus.flush) begin
            model_bubble();
        end else if (!bus.stall) begin
            live = bus.ex_valid && !m_redir && !m_halted;
            if (!live) begin
                model_bubble();
            end else begin
                jump   = bus.ex_is_jal || bus.ex_is_jalr;
                tk     = jump || (bus.ex_is_branch && bus.alu_bcond);
                m_valid = 1;
                m_alu  = jump ? bus.ex_pc + 32'd4 : bus.alu_result;
                m_rs2  = bus.ex_rs2_data;
                m_rd   = bus.ex_rd;
                m_mr   = bus.ex_mem_read;
                m_mw   = bus.ex_mem_write;
                m_rw   = (bus.ex_is_branch && !jump) ? 1'b0 : bus.ex_reg_write;
                m_m2r  = bus.ex_mem_to_reg;
                m_halt = bus.ex_halt;
                m_redir = tk;
                if (!tk)
                    m_tgt = 0;
                else if (bus.ex_is_jalr)
                    m_tgt = {bus.alu_result[31:1], 1'b0};
                else
                    m_tgt = bus.ex_pc + bus.ex_imm;
                if (bus.ex_halt) m_halted = 1;
            end
        end
    endtask

    task automatic check_all();
        expect_eq("mem_valid", 32'(bus.mem_valid), 32'(m_valid));
        expect_eq("mem_alu_result", bus.mem_alu_result, m_alu);
        expect_eq("mem_rs2_data", bus.mem_rs2_data, m_rs2);
        expect_eq("mem_rd", 32'(bus.mem_rd), 32'(m_rd));
        expect_eq("mem_mem_read", 32'(bus.mem_mem_read), 32'(m_mr));
        expect_eq("mem_mem_write", 32'(bus.mem_mem_write), 32'(m_mw));
        expect_eq("mem_reg_write", 32'(bus.mem_reg_write), 32'(m_rw));
        expect_eq("mem_mem_to_reg", 32'(bus.mem_mem_to_reg), 32'(m_m2r));
        expect_eq("mem_halt", 32'(bus.mem_halt), 32'(m_halt));
        expect_eq("redirect", 32'(bus.redirect), 32'(m_redir));
        expect_eq("redirect_target", bus.redirect_target, m_tgt);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_in();
        bus.stall = 0; bus.flush = 0; bus.ex_valid = 0;
        bus.ex_pc = 0; bus.ex_imm = 0; bus.alu_result = 0;
        bus.alu_bcond = 0; bus.ex_rs2_data = 0; bus.ex_rd = 0;
        bus.ex_is_branch = 0; bus.ex_is_jal = 0; bus.ex_is_jalr = 0;
        bus.ex_mem_read = 0; bus.ex_mem_write = 0; bus.ex_reg_write = 0;
        bus.ex_mem_to_reg = 0; bus.ex_halt = 0;
    endtask

    task automatic rand_in();
        int cls;
        bus.stall      = ($urandom_range(0, 7) == 0);
        bus.flush      = ($urandom_range(0, 15) == 0);
        bus.ex_valid   = ($urandom_range(0, 3) != 0);
        bus.ex_pc      = $urandom & ~32'd3;
        bus.ex_imm     = $urandom;
        bus.alu_result = $urandom;
        bus.alu_bcond  = 1'($urandom);
        bus.ex_rs2_data = $urandom;
        bus.ex_rd      = 5'($urandom);
        cls = $urandom_range(0, 5);
        bus.ex_is_branch = (cls == 1) || (cls == 2);
        bus.ex_is_jal    = (cls == 3);
        bus.ex_is_jalr   = (cls == 4);
        bus.ex_mem_read  = 1'($urandom);
        bus.ex_mem_write = 1'($urandom);
        bus.ex_reg_write = 1'($urandom);
        bus.ex_mem_to_reg = 1'($urandom);
        bus.ex_halt      = ($urandom_range(0, 31) == 0);
    endtask

    initial begin
        m_halted = 0;
        model_bubble();
        clear_in();

        // reset with every input high
        reset = 1;
        bus.stall = 1; bus.flush = 1; bus.ex_valid = 1;
        bus.ex_pc = '1; bus.ex_imm = '1; bus.alu_result = '1;
        bus.alu_bcond = 1; bus.ex_rs2_data = '1; bus.ex_rd = '1;
        bus.ex_is_branch = 1; bus.ex_is_jal = 1; bus.ex_is_jalr = 1;
        bus.ex_mem_read = 1; bus.ex_mem_write = 1; bus.ex_reg_write = 1;
        bus.ex_mem_to_reg = 1; bus.ex_halt = 1;
        step();
        step();
        expect_eq("rst_valid", 32'(bus.mem_valid), 32'd0);
        expect_eq("rst_redirect", 32'(bus.redirect), 32'd0);
        expect_eq("rst_halt", 32'(bus.mem_halt), 32'd0);
        reset = 0;
        clear_in();
        step();

        // plain ALU op
        bus.ex_valid = 1; bus.alu_result = 32'h10;
        bus.ex_rd = 5; bus.ex_reg_write = 1;
        step();
        expect_eq("add_valid", 32'(bus.mem_valid), 32'd1);
        expect_eq("add_result", bus.mem_alu_result, 32'h10);
        expect_eq("add_rd", 32'(bus.mem_rd), 32'd5);
        expect_eq("add_redirect", 32'(bus.redirect), 32'd0);

        // taken BEQ squashes the next instruction
        clear_in();
        bus.ex_valid = 1; bus.ex_is_branch = 1; bus.alu_bcond = 1;
        bus.ex_pc = 32'h100; bus.ex_imm = 32'h20; bus.ex_reg_write = 1;
        step();
        expect_eq("beq_redirect", 32'(bus.redirect), 32'd1);
        expect_eq("beq_target", bus.redirect_target, 32'h120);
        expect_eq("beq_reg_write", 32'(bus.mem_reg_write), 32'd0);
        clear_in();
        bus.ex_valid = 1; bus.ex_reg_write = 1; bus.alu_result = 32'h55;
        step();
        expect_eq("squash_valid", 32'(bus.mem_valid), 32'd0);
        expect_eq("squash_redirect", 32'(bus.redirect), 32'd0);

        // JALR clears bit 0, JAL wraps around
        clear_in();
        bus.ex_valid = 1; bus.ex_is_jalr = 1; bus.ex_pc = 32'h200;
        bus.alu_result = 32'h305; bus.ex_reg_write = 1;
        step();
        expect_eq("jalr_target", bus.redirect_target, 32'h304);
        expect_eq("jalr_link", bus.mem_alu_result, 32'h204);
        expect_eq("jalr_redirect", 32'(bus.redirect), 32'd1);
        clear_in();
        step();
        bus.ex_valid = 1; bus.ex_is_jal = 1;
        bus.ex_pc = 32'hFFFF_FFFC; bus.ex_imm = 32'd8;
        step();
        expect_eq("jal_wrap_target", bus.redirect_target, 32'h4);
        expect_eq("jal_wrap_link", bus.mem_alu_result, 32'h0);
        clear_in();
        step();

        // stall holds the redirect, flush beats stall
        bus.ex_valid = 1; bus.ex_is_branch = 1; bus.alu_bcond = 1;
        bus.ex_pc = 32'h400; bus.ex_imm = 32'hFFFF_FFF0;
        step();
        clear_in();
        bus.stall = 1; bus.ex_valid = 1;
        step();
        step();
        expect_eq("stall_redirect", 32'(bus.redirect), 32'd1);
        expect_eq("stall_target", bus.redirect_target, 32'h3F0);
        bus.flush = 1;
        step();
        expect_eq("flush_valid", 32'(bus.mem_valid), 32'd0);
        expect_eq("flush_redirect", 32'(bus.redirect), 32'd0);

        // halt is sticky until reset, flush does not clear it
        clear_in();
        bus.ex_valid = 1; bus.ex_halt = 1;
        step();
        expect_eq("halt_mem_halt", 32'(bus.mem_halt), 32'd1);
        bus.ex_halt = 0; bus.ex_reg_write = 1;
        for (int i = 0; i < 3; i++) begin
            bus.flush = (i == 1);
            step();
            expect_eq("halted_bubble", 32'(bus.mem_valid), 32'd0);
        end
        reset = 1;
        step();
        reset = 0;
        bus.flush = 0;
        step();
        expect_eq("unhalt_valid", 32'(bus.mem_valid), 32'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            reset = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
